// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the Mini-SRC hardwired control sequencer.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
// Contents: 5-bit opcode constants, opcode-class enum, mode enum,
// step encodings, the control-strobe bundle and the last-step lookup.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    CLS_ALU3, CLS_IMM, CLS_LDI, CLS_MULDIV, CLS_NEGNOT, CLS_LD, CLS_ST, CLS_BR,
    CLS_JR, CLS_JAL, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT
  } opclass_e;

  // Mode plus 3-bit step together form the sequencer state.
  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_RUN  = 2'd1,
    MODE_HALT = 2'd2
  } mode_e;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;
  localparam logic [2:0] T5 = 3'd5;
  localparam logic [2:0] T6 = 3'd6;
  localparam logic [2:0] T7 = 3'd7;

  // Field order matches the top-level port concatenation.
  typedef struct packed {
    logic pc_out, zhigh_out, zlow_out, mdr_out, hi_out, lo_out, inport_out, c_out;
    logic mar_in, pc_in, mdr_in, ir_in, y_in, hi_in, lo_in, zhigh_in, zlow_in;
    logic con_in, outport_in, r15_in;
    logic inc_pc, read, write;
    logic gra, grb, grc, r_in, r_out, ba_out;
  } ctrl_t;

  // Final execute step of each class; HALT never reaches execute.
  function automatic logic [2:0] last_step(opclass_e cls);
    case (cls)
      CLS_ALU3, CLS_IMM, CLS_LDI: last_step = T5;
      CLS_MULDIV, CLS_BR:         last_step = T6;
      CLS_NEGNOT, CLS_JAL:        last_step = T4;
      CLS_LD, CLS_ST:             last_step = T7;
      default:                    last_step = T3;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_opclass_decode.sv
// Maps the 5-bit opcode to its execute-sequence class.
// Latency: combinational.
// Backpressure: none.
// Ports: opcode (ir[31:27]) in, opclass out; unused opcodes decode as NOP.
module ctrl_opclass_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output opclass_e   opclass
);

  always_comb begin
    opclass = CLS_NOP;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL:
        opclass = CLS_ALU3;
      OP_ADDI, OP_ANDI, OP_ORI: opclass = CLS_IMM;
      OP_LDI:                   opclass = CLS_LDI;
      OP_MUL, OP_DIV:           opclass = CLS_MULDIV;
      OP_NEG, OP_NOT:           opclass = CLS_NEGNOT;
      OP_LD:                    opclass = CLS_LD;
      OP_ST:                    opclass = CLS_ST;
      OP_BR:                    opclass = CLS_BR;
      OP_JR:                    opclass = CLS_JR;
      OP_JAL:                   opclass = CLS_JAL;
      OP_IN:                    opclass = CLS_IN;
      OP_OUT:                   opclass = CLS_OUT;
      OP_MFHI:                  opclass = CLS_MFHI;
      OP_MFLO:                  opclass = CLS_MFLO;
      OP_HALT:                  opclass = CLS_HALT;
      default:                  opclass = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Hardwired Mini-SRC control sequencer: fetch T0-T2, execute T3-T7 per opcode class.
// Latency: one state per cycle; class latched at end of T2; strobes decoded from registered state.
// Backpressure: with CTRL_MEM_WAIT_EN defined, T1 / ld T6 / st T7 hold until mem_ready=1.
// Ports: clk, clr (async active-low), ir, con_ff, stop, [mem_ready]; bus-source selects,
// register load enables, IncPC/Read/Write, GRA/GRB/GRC/R_in/R_out/BAout, run.
module cpu_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned RESET_PC_HOLD = 0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        stop,
`ifdef CTRL_MEM_WAIT_EN
  input  logic        mem_ready,
`endif
  output logic        PCout,
  output logic        ZHighout,
  output logic        ZLowout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        Cout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        ZHighIn,
  output logic        ZLowIn,
  output logic        CONin,
  output logic        OutPortin,
  output logic        R15in,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        GRA,
  output logic        GRB,
  output logic        GRC,
  output logic        R_in,
  output logic        R_out,
  output logic        BAout,
  output logic        run
);

  localparam logic [1:0] HOLD_CYC = 2'(RESET_PC_HOLD);

  mode_e      mode_q, mode_d;
  logic [2:0] step_q, step_d;
  opclass_e   opclass_q, opclass_d;
  logic [1:0] hold_q, hold_d;
  opclass_e   dec_cls;
  logic       mem_wait;
  ctrl_t      ctrl;
  logic       ir_unused;

  // Only the opcode field steers sequencing; operand fields go to the datapath.
  assign ir_unused = ^ir[26:0];

  ctrl_opclass_decode u_decode (
    .opcode  (ir[31:27]),
    .opclass (dec_cls)
  );

  // Memory-access steps stall while the RAM is not ready.
  always_comb begin
    mem_wait = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
    if (mode_q == MODE_RUN && !mem_ready) begin
      if (step_q == T1 ||
          (step_q == T6 && opclass_q == CLS_LD) ||
          (step_q == T7 && opclass_q == CLS_ST)) begin
        mem_wait = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      mode_q    <= MODE_IDLE;
      step_q    <= T0;
      opclass_q <= CLS_NOP;
      hold_q    <= 2'd0;
    end else begin
      mode_q    <= mode_d;
      step_q    <= step_d;
      opclass_q <= opclass_d;
      hold_q    <= hold_d;
    end
  end

  always_comb begin
    mode_d    = mode_q;
    step_d    = step_q;
    opclass_d = opclass_q;
    hold_d    = hold_q;
    case (mode_q)
      MODE_IDLE: begin
        if (hold_q == HOLD_CYC) begin
          mode_d = MODE_RUN;
          step_d = T0;
          hold_d = 2'd0;
        end else begin
          hold_d = hold_q + 2'd1;
        end
      end
      MODE_RUN: begin
        if (!mem_wait) begin
          if (step_q == T2) begin
            // The class comes straight from IR here; halt skips execute entirely.
            opclass_d = dec_cls;
            if (dec_cls == CLS_HALT) begin
              mode_d = MODE_HALT;
              step_d = T0;
            end else begin
              step_d = T3;
            end
          end else if (step_q < T2) begin
            step_d = step_q + 3'd1;
          end else if (step_q == last_step(opclass_q)) begin
            step_d = T0;
            if (stop) mode_d = MODE_HALT;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
      end
      MODE_HALT: begin
        mode_d = MODE_HALT;
      end
      default: begin
        mode_d = MODE_IDLE;
        step_d = T0;
      end
    endcase
  end

  // Strobes depend only on registered state, except branch PCin which
  // qualifies on con_ff during T6.
  always_comb begin
    ctrl = '0;
    if (mode_q == MODE_RUN) begin
      case (step_q)
        T0: begin ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; end
        T1: begin ctrl.read = 1'b1; ctrl.mdr_in = 1'b1; end
        T2: begin ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1; end
        default: begin
          case (opclass_q)
            CLS_ALU3: case (step_q)
              T3: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
              T4: begin ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.zlow_in = 1'b1; end
              T5: begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
              default: ;
            endcase
            CLS_IMM, CLS_LDI: case (step_q)
              T3: begin
                ctrl.grb = 1'b1; ctrl.y_in = 1'b1;
                // ldi forces a zero base through the BA gate.
                if (opclass_q == CLS_LDI) ctrl.ba_out = 1'b1;
                else                      ctrl.r_out  = 1'b1;
              end
              T4: begin ctrl.c_out = 1'b1; ctrl.zlow_in = 1'b1; end
              T5: begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
              default: ;
            endcase
            CLS_MULDIV: case (step_q)
              T3: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
              T4: begin
                ctrl.grb = 1'b1; ctrl.r_out = 1'b1;
                ctrl.zhigh_in = 1'b1; ctrl.zlow_in = 1'b1;
              end
              T5: begin ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1; end
              T6: begin ctrl.zhigh_out = 1'b1; ctrl.hi_in = 1'b1; end
              default: ;
            endcase
            CLS_NEGNOT: case (step_q)
              T3: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.zlow_in = 1'b1; end
              T4: begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
              default: ;
            endcase
            CLS_LD, CLS_ST: case (step_q)
              T3: begin ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1; end
              T4: begin ctrl.c_out = 1'b1; ctrl.zlow_in = 1'b1; end
              T5: begin ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1; end
              T6: begin
                ctrl.mdr_in = 1'b1;
                if (opclass_q == CLS_LD) ctrl.read = 1'b1;
                else begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; end
              end
              T7: begin
                if (opclass_q == CLS_LD) begin
                  ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                end else begin
                  ctrl.write = 1'b1;
                end
              end
              default: ;
            endcase
            CLS_BR: case (step_q)
              T3: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1; end
              T4: begin ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1; end
              T5: begin ctrl.c_out = 1'b1; ctrl.zlow_in = 1'b1; end
              T6: begin ctrl.zlow_out = 1'b1; ctrl.pc_in = con_ff; end
              default: ;
            endcase
            CLS_JR: if (step_q == T3) begin
              ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1;
            end
            CLS_JAL: case (step_q)
              T3: begin ctrl.pc_out = 1'b1; ctrl.r15_in = 1'b1; end
              T4: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
              default: ;
            endcase
            CLS_IN:   if (step_q == T3) begin ctrl.inport_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
            CLS_OUT:  if (step_q == T3) begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.outport_in = 1'b1; end
            CLS_MFHI: if (step_q == T3) begin ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
            CLS_MFLO: if (step_q == T3) begin ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
            default: ;
          endcase
        end
      endcase
    end
  end

  assign {PCout, ZHighout, ZLowout, MDRout, HIout, LOout, InPortout, Cout,
          MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn,
          CONin, OutPortin, R15in, IncPC, Read, Write,
          GRA, GRB, GRC, R_in, R_out, BAout} = ctrl;

  assign run = (mode_q == MODE_RUN);

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench: a step-table model (strobe names per step, from the opcode
// table) feeds an expectation queue that is compared every cycle, plus a
// handful of literal spot checks on individual strobes.
module tb_cpu_control_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] ir;
  logic        con_ff;
  logic        stop;
`ifdef CTRL_MEM_WAIT_EN
  logic        mem_ready;
`endif
  logic PCout, ZHighout, ZLowout, MDRout, HIout, LOout, InPortout, Cout;
  logic MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn;
  logic CONin, OutPortin, R15in, IncPC, Read, Write;
  logic GRA, GRB, GRC, R_in, R_out, BAout, run;

  always #5 clk = ~clk;

  cpu_control_unit dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .stop(stop),
`ifdef CTRL_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .PCout(PCout), .ZHighout(ZHighout), .ZLowout(ZLowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
    .CONin(CONin), .OutPortin(OutPortin), .R15in(R15in), .IncPC(IncPC),
    .Read(Read), .Write(Write), .GRA(GRA), .GRB(GRB), .GRC(GRC),
    .R_in(R_in), .R_out(R_out), .BAout(BAout), .run(run)
  );

  logic [28:0] dut_v;
  assign dut_v = {PCout, ZHighout, ZLowout, MDRout, HIout, LOout, InPortout, Cout,
                  MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn,
                  CONin, OutPortin, R15in, IncPC, Read, Write,
                  GRA, GRB, GRC, R_in, R_out, BAout};

  string sig_names [29] = '{"PCout", "ZHighout", "ZLowout", "MDRout", "HIout", "LOout",
                            "InPortout", "Cout", "MARin", "PCin", "MDRin", "IRin", "Yin",
                            "HIin", "LOin", "ZHighIn", "ZLowIn", "CONin", "OutPortin",
                            "R15in", "IncPC", "Read", "Write", "GRA", "GRB", "GRC",
                            "R_in", "R_out", "BAout"};

  localparam string FETCH = "PCout MARin IncPC|Read MDRin|MDRout IRin";

  typedef struct {
    logic [28:0] v;
    logic        run;
    string       tag;
  } exp_t;

  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_errors = 0;

  int unsigned op_list [26] = '{4, 5, 6, 7, 8, 9, 10, 11, 2, 1, 12, 13, 14, 15, 16,
                                17, 18, 20, 21, 22, 23, 24, 25, 26, 28, 31};

  // Execute steps per opcode as strobe-name lists; "PCin?" means PCin when con_ff=1.
  function automatic string exec_of(logic [4:0] op);
    if (op == 5'd0)                    return "GRB BAout Yin|Cout ZLowIn|ZLowout MARin|Read MDRin|MDRout GRA R_in";
    if (op == 5'd1)                    return "GRB BAout Yin|Cout ZLowIn|ZLowout GRA R_in";
    if (op == 5'd2)                    return "GRB BAout Yin|Cout ZLowIn|ZLowout MARin|GRA R_out MDRin|Write";
    if (op >= 5'd3 && op <= 5'd11)     return "GRB R_out Yin|GRC R_out ZLowIn|ZLowout GRA R_in";
    if (op >= 5'd12 && op <= 5'd14)    return "GRB R_out Yin|Cout ZLowIn|ZLowout GRA R_in";
    if (op == 5'd15 || op == 5'd16)    return "GRA R_out Yin|GRB R_out ZHighIn ZLowIn|ZLowout LOin|ZHighout HIin";
    if (op == 5'd17 || op == 5'd18)    return "GRB R_out ZLowIn|ZLowout GRA R_in";
    if (op == 5'd19)                   return "GRA R_out CONin|PCout Yin|Cout ZLowIn|ZLowout PCin?";
    if (op == 5'd20)                   return "GRA R_out PCin";
    if (op == 5'd21)                   return "PCout R15in|GRA R_out PCin";
    if (op == 5'd22)                   return "InPortout GRA R_in";
    if (op == 5'd23)                   return "GRA R_out OutPortin";
    if (op == 5'd24)                   return "HIout GRA R_in";
    if (op == 5'd25)                   return "LOout GRA R_in";
    return "";  // nop and undefined: one empty step
  endfunction

  function automatic logic [28:0] lookup(string tok, logic c);
    logic [28:0] v;
    v = '0;
    for (int i = 0; i < 29; i++) begin
      if (tok == sig_names[i]) v[28-i] = 1'b1;
      if (tok == "PCin?" && sig_names[i] == "PCin" && c) v[28-i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [28:0] enc(string s, logic c);
    logic [28:0] v;
    int start;
    v = '0;
    start = 0;
    for (int i = 0; i <= s.len(); i++) begin
      if (i == s.len() || s[i] == 8'h20) begin
        if (i > start) v = v | lookup(s.substr(start, i - 1), c);
        start = i + 1;
      end
    end
    return v;
  endfunction

  task automatic push_exp(logic [28:0] v, logic r, string tag);
    exp_t e;
    e.v = v; e.run = r; e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Called in the T0 cycle. Pushes one expectation per cycle; trunc>0 keeps only
  // the first trunc steps, w1 extra copies of T1 model memory wait.
  task automatic issue(input logic [31:0] instr, input logic c, input logic s,
                       input int trunc, input int w1, output int n);
    string full;
    string cur;
    int start;
    int step;
    ir = instr; con_ff = c; stop = s;
    full = (instr[31:27] == 5'd27) ? FETCH : {FETCH, "|", exec_of(instr[31:27])};
    n = 0; start = 0; step = 0;
    for (int i = 0; i <= full.len(); i++) begin
      if (i == full.len() || full[i] == 8'h7C) begin
        cur = (i > start) ? full.substr(start, i - 1) : "";
        start = i + 1;
        for (int r = 0; r <= ((step == 1) ? w1 : 0); r++) begin
          if (trunc == 0 || step < trunc) begin
            push_exp(enc(cur, c), 1'b1, $sformatf("op%0d_T%0d", instr[31:27], step));
            n++;
          end
        end
        step++;
      end
    end
  endtask

  task automatic cyc(int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse clr for one cycle from a post-edge point; returns in the first T0 cycle.
  task automatic do_reset();
    push_exp('0, 1'b0, "in_reset");
    clr = 1'b0;
    cyc(1);
    push_exp('0, 1'b0, "idle_after_release");
    clr = 1'b1;
    cyc(1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (dut_v !== e.v || run !== e.run) begin
        n_errors++;
        $display("FAIL %s: got strobes=%h run=%b expected strobes=%h run=%b",
                 e.tag, dut_v, run, e.v, e.run);
      end
      n_checks++;
      if ($countones(dut_v[28:21]) > 1) begin
        n_errors++;
        $display("FAIL bus_sources_%s: got %0d active selects expected at most 1",
                 e.tag, $countones(dut_v[28:21]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    clr = 1'b0; ir = '0; con_ff = 1'b0; stop = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    @(posedge clk);
    #1;
    do_reset();
    chk("release_T0", {PCout, MARin, IncPC, run}, 4'b1111);

    // add R1,R2,R3
    issue(32'h18918000, 1'b0, 1'b0, 0, 0, n);
    cyc(3);
    chk("add_T3", {GRB, R_out, Yin, GRC, ZLowIn}, 5'b11100);
    cyc(3);
    chk("add_cycle7_T0", {PCout, MARin, IncPC}, 3'b111);

    // ld R1,0x55(R0)
    issue(32'h00800055, 1'b0, 1'b0, 0, 0, n);
    cyc(1);
    chk("ld_T1_read", Read, 1'b1);
    cyc(2);
    chk("ld_T3_baout", {BAout, R_out}, 2'b10);
    cyc(3);
    chk("ld_T6_read", {Read, MDRin}, 2'b11);
    cyc(1);
    chk("ld_T7", {MDRout, GRA, R_in}, 3'b111);
    cyc(1);
    chk("ld_8cycle_T0", {PCout, n}, {1'b1, 32'd8});

    // brnz R5,16 taken / not taken
    issue(32'h9A880010, 1'b1, 1'b0, 0, 0, n);
    cyc(6);
    chk("br_taken_T6", {ZLowout, PCin}, 2'b11);
    cyc(1);
    issue(32'h9A880010, 1'b0, 1'b0, 0, 0, n);
    cyc(6);
    chk("br_not_taken_T6", {ZLowout, PCin}, 2'b10);
    cyc(1);
    chk("br_not_taken_next_T0", PCout, 1'b1);

    // Remaining opcodes, including undefined ones
    foreach (op_list[i]) begin
      issue({op_list[i][4:0], 27'd0}, 1'b0, 1'b0, 0, 0, n);
      cyc(n);
    end

    // halt: run drops at T3, nothing strobes for 20 cycles, clr restarts
    issue(32'hD8000000, 1'b0, 1'b0, 0, 0, n);
    for (int i = 0; i < 20; i++) push_exp('0, 1'b0, "halted");
    cyc(3);
    chk("halt_run_low_T3", run, 1'b0);
    cyc(20);
    do_reset();
    chk("halt_restart_T0", {PCout, MARin, IncPC, run}, 4'b1111);

    // stop during add: instruction completes, then HALT
    issue(32'h18918000, 1'b0, 1'b1, 0, 0, n);
    for (int i = 0; i < 3; i++) push_exp('0, 1'b0, "stopped");
    cyc(6);
    chk("stop_halt", {run, IRin, PCout}, 3'b000);
    cyc(3);
    stop = 1'b0;
    do_reset();

    // clr during T4 of mul aborts immediately
    issue(32'h78000000, 1'b0, 1'b0, 4, 0, n);
    cyc(4);
    chk("mul_T4", {GRB, R_out, ZHighIn, ZLowIn}, 4'b1111);
    clr = 1'b0;
    push_exp('0, 1'b0, "mul_abort");
    #1;
    chk("mul_abort_same_cycle", {dut_v, run}, 30'd0);
    cyc(1);
    push_exp('0, 1'b0, "idle_after_abort");
    clr = 1'b1;
    cyc(1);
    chk("mul_abort_T0", {PCout, MARin, IncPC}, 3'b111);

`ifdef CTRL_MEM_WAIT_EN
    // nop with mem_ready low for the first 3 cycles of T1
    issue(32'hD0000000, 1'b0, 1'b0, 0, 3, n);
    mem_ready = 1'b0;
    cyc(3);
    chk("memwait_T1_held", {Read, MDRin}, 2'b11);
    cyc(1);
    mem_ready = 1'b1;
    cyc(1);
    chk("memwait_T2", {MDRout, IRin}, 2'b11);
    cyc(2);
`endif

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
